// File: rtl/mem_preload_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_preload_unit                                                     |
// | Packs a byte stream big-endian into 32-bit words, writes them to     |
// | data memory, then releases the AES core from reset.                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_preload_unit #(
  parameter int NUM_WORDS = 8,
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               in_valid,
  input  logic [7:0]                         in_data,
  output logic                               in_ready,
  output logic                               mem_we,
  output logic [ADDR_W-1:0]                  mem_addr,
  output logic [31:0]                        mem_wdata,
  output logic                               core_rst,
  output logic                               done,
  output logic [$clog2(NUM_WORDS+1)-1:0]     word_count
);

  localparam int CNT_W = $clog2(NUM_WORDS + 1);

  if (NUM_WORDS < 1 || BASE_ADDR < 0 ||
      (longint'(BASE_ADDR) + longint'(NUM_WORDS) - 1) >= (longint'(1) << ADDR_W)) begin : g_bad_params
    $error("mem_preload_unit: NUM_WORDS/BASE_ADDR do not fit ADDR_W");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [1:0]         r_byte_cnt;
  logic [23:0]        r_shift;
  logic               w_xfer;
  logic [CNT_W-1:0]   w_wc_inc;
  logic               w_last_word;

  assign in_ready    = (r_state == S_LOAD);
  assign w_xfer      = in_valid & in_ready;
  assign w_wc_inc    = word_count + CNT_W'(1);
  assign w_last_word = (w_wc_inc == CNT_W'(NUM_WORDS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_LOAD;
      S_LOAD:  if (w_xfer && r_byte_cnt == 2'd3) w_next = S_WRITE;
      S_WRITE: w_next = w_last_word ? S_RUN : S_LOAD;
      S_RUN:   if (start) w_next = S_LOAD;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_rst   <= 1'b1;
      done       <= 1'b0;
      word_count <= '0;
      r_byte_cnt <= '0;
      r_shift    <= '0;
    end else begin
      mem_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            word_count <= '0;
            r_byte_cnt <= '0;
          end
        end
        S_LOAD: begin
          if (w_xfer) begin
            r_shift    <= {r_shift[15:0], in_data};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            // Fourth byte completes the word; issue the write straight from the shifter.
            if (r_byte_cnt == 2'd3) begin
              mem_we    <= 1'b1;
              mem_addr  <= ADDR_W'(BASE_ADDR) + ADDR_W'(word_count);
              mem_wdata <= {r_shift, in_data};
            end
          end
        end
        S_WRITE: begin
          word_count <= w_wc_inc;
          r_byte_cnt <= '0;
          if (w_last_word) begin
            core_rst <= 1'b0;
            done     <= 1'b1;
          end
        end
        S_RUN: begin
          if (start) begin
            core_rst   <= 1'b1;
            done       <= 1'b0;
            word_count <= '0;
            r_byte_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_preload_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_preload_unit                                                  |
// | Randomized self-checking bench with a word-level reference model.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mem_preload_unit;

  localparam int NUM_WORDS = 8;
  localparam int ADDR_W    = 10;
  localparam int BASE_ADDR = 0;
  localparam int NB        = 4 * NUM_WORDS;
  localparam int CW        = $clog2(NUM_WORDS + 1);

  logic              clk = 1'b0;
  logic              rst, start, in_valid;
  logic [7:0]        in_data;
  logic              in_ready, mem_we, core_rst, done;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [CW-1:0]     word_count;

  int n_checks = 0;
  int n_err    = 0;
  logic [7:0]  stim [NB];
  int          wa_q [$];
  logic [31:0] wd_q [$];
  logic        prev_we = 1'b0;

  mem_preload_unit #(.NUM_WORDS(NUM_WORDS), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_rst(core_rst), .done(done), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor: every write is a single-cycle pulse seen with in_ready low.
  always @(negedge clk) begin
    if (mem_we) begin
      chk("we_single_cycle", 32'(prev_we), 32'd0);
      chk("rdy_low_in_write", 32'(in_ready), 32'd0);
      wa_q.push_back(int'(mem_addr));
      wd_q.push_back(mem_wdata);
    end
    prev_we = mem_we;
  end

  task automatic check_reset(input string tag);
    chk({tag, "_core_rst"}, 32'(core_rst), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_word_count"}, 32'(word_count), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
  endtask

  // mode 0: back-to-back, 1: valid pattern 1,0,0, 2: random valid
  task automatic do_load(input int mode, input int nbytes, input int restart_at, output int edges);
    int idx;
    int n;
    bit restarted;
    idx = 0; n = 0; restarted = 0;
    wa_q.delete();
    wd_q.delete();
    @(negedge clk);
    start = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("start_core_rst", 32'(core_rst), 32'd1);
    chk("start_done", 32'(done), 32'd0);
    chk("start_word_count", 32'(word_count), 32'd0);
    chk("start_in_ready", 32'(in_ready), 32'd1);
    while (!done && n < 3000 && !(nbytes < NB && idx >= nbytes)) begin
      start = 1'b0;
      if (restart_at >= 0 && !restarted && idx == restart_at) begin
        start = 1'b1;
        restarted = 1'b1;
      end
      if (idx < NB) begin
        case (mode)
          0:       in_valid = 1'b1;
          1:       in_valid = (n % 3 == 0);
          default: in_valid = ($urandom_range(1) == 1);
        endcase
        in_data = stim[idx];
      end else begin
        in_valid = 1'b0;
      end
      if (in_valid && in_ready) idx++;
      @(negedge clk);
      n++;
    end
    start = 1'b0; in_valid = 1'b0;
    if (n >= 3000) chk("load_timeout", 32'd0, 32'd1);
    edges = n;
  endtask

  task automatic verify(input int nw);
    logic [31:0] exp;
    chk("n_writes", 32'(wa_q.size()), 32'(nw));
    for (int k = 0; k < nw && k < wa_q.size(); k++) begin
      exp = {stim[4*k], stim[4*k+1], stim[4*k+2], stim[4*k+3]};
      chk("waddr", 32'(wa_q[k]), 32'(BASE_ADDR + k));
      chk("wdata", wd_q[k], exp);
    end
  endtask

  task automatic check_running();
    chk("run_done", 32'(done), 32'd1);
    chk("run_core_rst", 32'(core_rst), 32'd0);
    chk("run_word_count", 32'(word_count), 32'(NUM_WORDS));
    chk("run_hold_addr", 32'(mem_addr), 32'(BASE_ADDR + NUM_WORDS - 1));
    chk("run_hold_wdata", mem_wdata, {stim[NB-4], stim[NB-3], stim[NB-2], stim[NB-1]});
  endtask

  initial begin
    int edges;
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #3 rst = 1'b1;
    #1 check_reset("rst_async");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("rst_hold");

    // Full load, back-to-back bytes
    for (int i = 0; i < NB; i++) stim[i] = 8'(i);
    do_load(0, NB, -1, edges);
    chk("done_edge", 32'(edges), 32'(5 * NUM_WORDS));
    verify(NUM_WORDS);
    check_running();
    // Bytes offered in RUN are never accepted
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'hAA;
      chk("run_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("run_no_extra_writes", 32'(wa_q.size()), 32'(NUM_WORDS));
    chk("run_done_stays", 32'(done), 32'd1);

    // Stalled stream
    do_load(1, NB, -1, edges);
    chk("stall_slower", 32'(edges > 5 * NUM_WORDS), 32'd1);
    verify(NUM_WORDS);
    check_running();

    // Ignored start mid-load, random data and random valid
    for (int i = 0; i < NB; i++) stim[i] = 8'($urandom);
    do_load(2, NB, 6, edges);
    verify(NUM_WORDS);
    check_running();

    // Reset after two bytes of word 3
    for (int i = 0; i < NB; i++) stim[i] = 8'($urandom);
    do_load(2, 14, -1, edges);
    repeat (2) @(negedge clk);
    chk("partial_word_count", 32'(word_count), 32'd3);
    verify(3);
    #2 rst = 1'b1;
    #1 check_reset("rst_mid_word");
    @(negedge clk);
    rst = 1'b0;
    chk("no_write_after_rst", 32'(wa_q.size()), 32'd3);
    for (int i = 0; i < NB; i++) stim[i] = 8'(i);
    do_load(0, NB, -1, edges);
    verify(NUM_WORDS);
    check_running();

    // Restart from RUN with all-ones data
    for (int i = 0; i < NB; i++) stim[i] = 8'hFF;
    do_load(0, NB, -1, edges);
    chk("restart_done_edge", 32'(edges), 32'(5 * NUM_WORDS));
    verify(NUM_WORDS);
    check_running();

    // A few more random loads
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NB; i++) stim[i] = 8'($urandom);
      do_load(2, NB, -1, edges);
      verify(NUM_WORDS);
      check_running();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
